// File: rtl/gpio_irq_pkg29.sv
// Shared constants for the GPIO interrupt sub-unit: register map and reset values.
package gpio_irq_pkg29;

  localparam int unsigned MAX_WIDTH = 32;

  // Register byte addresses
  localparam int unsigned A_DIR    = 'h04;
  localparam int unsigned A_OE     = 'h08;
  localparam int unsigned A_OUT    = 'h0C;
  localparam int unsigned A_IN     = 'h10;
  localparam int unsigned A_TYPE   = 'h14;
  localparam int unsigned A_POL    = 'h18;
  localparam int unsigned A_BOTH   = 'h1C;
  localparam int unsigned A_STATUS = 'h20;
  localparam int unsigned A_MASK   = 'h24;
  localparam int unsigned A_DBLIM  = 'h28;
  localparam int unsigned A_OUTSET = 'h2C;
  localparam int unsigned A_OUTCLR = 'h30;

  // Reset values, sliced down to WIDTH / DB_W by the users
  localparam logic [MAX_WIDTH-1:0] REG_RST   = '0;
  localparam logic [MAX_WIDTH-1:0] DBLIM_RST = '0;

endpackage

// File: rtl/gpio_pin_filter29.sv
// One pin's input path: synchroniser, debounce filter, delayed copy and event detect.
module gpio_pin_filter29 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pin,
  input  logic [DB_W-1:0] i_dblim,
  input  logic            i_type,
  input  logic            i_pol,
  input  logic            i_both,
  output logic            o_f,
  output logic            o_event
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_cnt;
  logic                   r_f;
  logic                   r_fq;
  logic                   w_sy;
  logic                   w_rise;
  logic                   w_fall;

  assign w_sy = r_sync[SYNC_STAGES-1];

  // Synchronise the pad, debounce it into f and keep a one-cycle-old copy of f
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_f    <= 1'b0;
      r_fq   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_fq   <= r_f;
      if (w_sy == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt < i_dblim) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        // also commits if DBLIM was lowered below the running count
        r_f   <= w_sy;
        r_cnt <= '0;
      end
    end
  end

  assign w_rise = r_f & ~r_fq;
  assign w_fall = ~r_f & r_fq;

  // Select level or edge event according to the pin's configuration
  always_comb begin
    if (i_type) begin
      o_event = (r_f == i_pol);
    end else if (i_both) begin
      o_event = w_rise | w_fall;
    end else begin
      o_event = i_pol ? w_rise : w_fall;
    end
  end

  assign o_f = r_f;

endmodule

// File: rtl/gpio_irq_subunit29.sv
// GPIO bank: register file, read mux, STATUS/interrupt logic and per-pin filters.
module gpio_irq_subunit29
  import gpio_irq_pkg29::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 8
) (
  input  logic              pclk29,
  input  logic              n_reset29,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata29,
  input  logic [WIDTH-1:0]  pin_in29,
  input  logic [WIDTH-1:0]  tri_state_enable29,
  output logic [WIDTH-1:0]  rdata29,
  output logic [WIDTH-1:0]  pin_out29,
  output logic [WIDTH-1:0]  pin_oe_n29,
  output logic [WIDTH-1:0]  interrupt29,
  output logic              irq_any29
);

  localparam logic [ADDR_W-1:0] L_DIR    = ADDR_W'(A_DIR);
  localparam logic [ADDR_W-1:0] L_OE     = ADDR_W'(A_OE);
  localparam logic [ADDR_W-1:0] L_OUT    = ADDR_W'(A_OUT);
  localparam logic [ADDR_W-1:0] L_IN     = ADDR_W'(A_IN);
  localparam logic [ADDR_W-1:0] L_TYPE   = ADDR_W'(A_TYPE);
  localparam logic [ADDR_W-1:0] L_POL    = ADDR_W'(A_POL);
  localparam logic [ADDR_W-1:0] L_BOTH   = ADDR_W'(A_BOTH);
  localparam logic [ADDR_W-1:0] L_STATUS = ADDR_W'(A_STATUS);
  localparam logic [ADDR_W-1:0] L_MASK   = ADDR_W'(A_MASK);
  localparam logic [ADDR_W-1:0] L_DBLIM  = ADDR_W'(A_DBLIM);
  localparam logic [ADDR_W-1:0] L_OUTSET = ADDR_W'(A_OUTSET);
  localparam logic [ADDR_W-1:0] L_OUTCLR = ADDR_W'(A_OUTCLR);
  localparam int unsigned       CW       = (WIDTH < DB_W) ? WIDTH : DB_W;

  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_oe;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_type;
  logic [WIDTH-1:0] r_pol;
  logic [WIDTH-1:0] r_both;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_mask;
  logic [DB_W-1:0]  r_dblim;
  logic [WIDTH-1:0] r_rdata;

  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_dblim_rd;
  logic [WIDTH-1:0] w_rd_mux;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_pin_filter29 #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_W       (DB_W)
    ) u_filter (
      .i_clk  (pclk29),
      .i_rst_n(n_reset29),
      .i_pin  (pin_in29[g]),
      .i_dblim(r_dblim),
      .i_type (r_type[g]),
      .i_pol  (r_pol[g]),
      .i_both (r_both[g]),
      .o_f    (w_f[g]),
      .o_event(w_event[g])
    );
  end

  assign w_w1c = (write && (addr == L_STATUS)) ? wdata29 : '0;

  // Zero-extend or truncate DBLIM to the bus width for readback
  always_comb begin
    w_dblim_rd = '0;
    for (int unsigned i = 0; i < CW; i++) begin
      w_dblim_rd[i] = r_dblim[i];
    end
  end

  // Read mux; write-only and unmapped addresses return the filtered inputs
  always_comb begin
    w_rd_mux = w_f;
    case (addr)
      L_DIR:    w_rd_mux = r_dir;
      L_OE:     w_rd_mux = r_oe;
      L_OUT:    w_rd_mux = r_out;
      L_IN:     w_rd_mux = w_f;
      L_TYPE:   w_rd_mux = r_type;
      L_POL:    w_rd_mux = r_pol;
      L_BOTH:   w_rd_mux = r_both;
      L_STATUS: w_rd_mux = r_status;
      L_MASK:   w_rd_mux = r_mask;
      L_DBLIM:  w_rd_mux = w_dblim_rd;
      default:  w_rd_mux = w_f;
    endcase
  end

  // Register writes, STATUS accumulation and registered read data
  always_ff @(posedge pclk29) begin
    if (!n_reset29) begin
      r_dir    <= REG_RST[WIDTH-1:0];
      r_oe     <= REG_RST[WIDTH-1:0];
      r_out    <= REG_RST[WIDTH-1:0];
      r_type   <= REG_RST[WIDTH-1:0];
      r_pol    <= REG_RST[WIDTH-1:0];
      r_both   <= REG_RST[WIDTH-1:0];
      r_status <= REG_RST[WIDTH-1:0];
      r_mask   <= REG_RST[WIDTH-1:0];
      r_dblim  <= DBLIM_RST[DB_W-1:0];
      r_rdata  <= '0;
    end else begin
      r_rdata  <= read ? w_rd_mux : '0;
      // set has priority over the write-1-to-clear
      r_status <= (r_status & ~w_w1c) | (w_event & r_dir);
      if (write) begin
        case (addr)
          L_DIR:    r_dir   <= wdata29;
          L_OE:     r_oe    <= wdata29;
          L_OUT:    r_out   <= wdata29;
          L_TYPE:   r_type  <= wdata29;
          L_POL:    r_pol   <= wdata29;
          L_BOTH:   r_both  <= wdata29;
          L_MASK:   r_mask  <= wdata29;
          L_DBLIM:  r_dblim <= DB_W'(wdata29);
          L_OUTSET: r_out   <= r_out | wdata29;
          L_OUTCLR: r_out   <= r_out & ~wdata29;
          default:  ;
        endcase
      end
    end
  end

  assign rdata29     = r_rdata;
  assign pin_out29   = r_out;
  assign pin_oe_n29  = ~(r_oe & ~r_dir) | tri_state_enable29;
  assign interrupt29 = r_status & r_mask;
  assign irq_any29   = |interrupt29;

endmodule
